bus_uart_tx_device: RTL and testbench



---
 rtl/bus_uart_tx_device.sv | 256 +++++++++++++++++++++++++
 tb/tb_bus_uart_tx_device.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_uart_tx_device.sv
// ---------------------------------------------------------------------------
// bus_uart_tx_device
//
// Memory-mapped UART transmitter acting as a responder on the core data bus.
// Bytes written to TXDATA are queued in a circular FIFO and sent 8N1,
// LSB first, on uart_tx. STATUS and DIVISOR are readable with one cycle of
// read latency.
//
// Register window (16 bytes at BASE_ADDRESS):
//   0x0 TXDATA  (W)  byte_enable[0] pushes write_data[7:0]; reads return 0
//   0x4 STATUS  (RW) {OVERFLOW, EMPTY, FULL, BUSY} in [3:0], count in [8:4];
//                    write 1 to bit3 (byte_enable[0]) clears OVERFLOW
//   0x8 DIVISOR (RW) clock cycles per UART bit in [15:0], per-lane writes
//   0xC reserved     reads 0, writes ignored
//
// Ports:
//   clock             system clock, rising-edge active
//   reset             asynchronous, active-high reset
//   bus_address       byte address from the core
//   bus_read_data     registered read data (valid the cycle after a read)
//   bus_write_data    write data from the core
//   bus_byte_enable   byte lanes of the access
//   bus_read_enable   read strobe, one cycle per access
//   bus_write_enable  write strobe, one cycle per access
//   uart_tx           serial output, idles high
//   tx_irq            high while the FIFO is empty and the serializer idle
// ---------------------------------------------------------------------------
module bus_uart_tx_device #(
    parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000,
    parameter int          CLOCK_DIV    = 434,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    output logic [31:0] bus_read_data,
    input  logic [31:0] bus_write_data,
    input  logic [3:0]  bus_byte_enable,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic        uart_tx,
    output logic        tx_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic       hit;
    logic [1:0] offset;

    assign hit    = (bus_address[31:4] == BASE_ADDRESS[31:4]);
    assign offset = bus_address[3:2];

    // Bits of the bus that this block never looks at.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus_address[1:0], bus_write_data[31:16],
                           bus_byte_enable[3:2]};

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        overflow;
    logic [15:0] divisor;

    tx_state_t   state;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_idx;
    logic [15:0] baud_cnt;
    logic [15:0] eff_div;

    // -----------------------------------------------------------------------
    // FIFO status. The extra pointer bit tells full from empty when the
    // index bits match.
    // -----------------------------------------------------------------------
    logic        fifo_empty;
    logic        fifo_full;
    logic [AW:0] fifo_count;
    logic [4:0]  count_field;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                         (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_count  = wr_ptr - rd_ptr;
    assign count_field = 5'(fifo_count);

    // -----------------------------------------------------------------------
    // Push / pop control. A pop in the same cycle frees a slot, so a push
    // into a full FIFO is still accepted when the serializer takes the head.
    // -----------------------------------------------------------------------
    logic push_req;
    logic pop;
    logic push_accept;
    logic overflow_set;
    logic overflow_clr;
    logic div_write;

    assign push_req     = bus_write_enable && hit && (offset == 2'd0) &&
                          bus_byte_enable[0];
    assign pop          = (state == ST_IDLE) && !fifo_empty;
    assign push_accept  = push_req && (!fifo_full || pop);
    assign overflow_set = push_req && fifo_full && !pop;
    assign overflow_clr = bus_write_enable && hit && (offset == 2'd1) &&
                          bus_byte_enable[0] && bus_write_data[3];
    assign div_write    = bus_write_enable && hit && (offset == 2'd2);

    // NOTE: the FIFO storage has no reset; the pointers alone define which
    // entries are valid, so clearing the array would only cost flops.
    always_ff @(posedge clock) begin
        if (push_accept) begin
            fifo_mem[wr_ptr[AW-1:0]] <= bus_write_data[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            divisor  <= 16'(CLOCK_DIV);
        end else begin
            if (push_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
            if (div_write && bus_byte_enable[0]) begin
                divisor[7:0] <= bus_write_data[7:0];
            end
            if (div_write && bus_byte_enable[1]) begin
                divisor[15:8] <= bus_write_data[15:8];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read path. Values are sampled before this cycle's write lands, so a
    // simultaneous read and write returns the old contents.
    // -----------------------------------------------------------------------
    logic [31:0] read_value;

    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        read_value = 32'd0;
        case (offset)
            2'd1: read_value = {23'd0, count_field, overflow, fifo_empty,
                                fifo_full, (state != ST_IDLE)};
            2'd2: read_value = {16'd0, divisor};
            default: read_value = 32'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_read_data <= 32'd0;
        end else if (bus_read_enable && hit) begin
            bus_read_data <= read_value;
        end else begin
            bus_read_data <= 32'd0;
        end
    end

    // -----------------------------------------------------------------------
    // Serializer. The bit period is latched at frame start so DIVISOR writes
    // mid-frame take effect on the next frame only. A divisor of 0 runs at
    // one cycle per bit.
    // -----------------------------------------------------------------------
    logic [15:0] start_div;
    assign start_div = (divisor == 16'd0) ? 16'd1 : divisor;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            shift_reg <= 8'd0;
            bit_idx   <= 3'd0;
            baud_cnt  <= 16'd0;
            eff_div   <= 16'd1;
            uart_tx   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shift_reg <= fifo_mem[rd_ptr[AW-1:0]];
                        eff_div   <= start_div;
                        baud_cnt  <= start_div - 16'd1;
                        uart_tx   <= 1'b0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == 16'd0) begin
                        bit_idx  <= 3'd0;
                        uart_tx  <= shift_reg[0];
                        baud_cnt <= eff_div - 16'd1;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= eff_div - 16'd1;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == 16'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Interrupt reflects the registered FIFO/serializer state of the
    // previous cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_irq <= 1'b1;
        end else begin
            tx_irq <= fifo_empty && (state == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_bus_uart_tx_device.sv
// ---------------------------------------------------------------------------
// tb_bus_uart_tx_device
//
// Directed bench for bus_uart_tx_device. Bus tasks start and end on a falling
// clock edge, so each access occupies exactly one rising edge and outputs are
// always sampled half a cycle away from it.
// ---------------------------------------------------------------------------
module tb_bus_uart_tx_device;

    localparam logic [31:0] A_TXDATA  = 32'h1000_0000;
    localparam logic [31:0] A_STATUS  = 32'h1000_0004;
    localparam logic [31:0] A_DIVISOR = 32'h1000_0008;
    localparam logic [31:0] A_RESVD   = 32'h1000_000C;
    localparam logic [31:0] A_MISS    = 32'h2000_0000;

    logic        clock;
    logic        reset;
    logic [31:0] bus_address;
    logic [31:0] bus_read_data;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic        uart_tx;
    logic        tx_irq;

    int n_checks = 0;
    int n_fail   = 0;

    bus_uart_tx_device #(
        .BASE_ADDRESS(32'h1000_0000),
        .CLOCK_DIV   (434),
        .FIFO_DEPTH  (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .bus_address     (bus_address),
        .bus_read_data   (bus_read_data),
        .bus_write_data  (bus_write_data),
        .bus_byte_enable (bus_byte_enable),
        .bus_read_enable (bus_read_enable),
        .bus_write_enable(bus_write_enable),
        .uart_tx         (uart_tx),
        .tx_irq          (tx_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] be);
        bus_address      = addr;
        bus_write_data   = data;
        bus_byte_enable  = be;
        bus_write_enable = 1'b1;
        @(negedge clock);
        bus_write_enable = 1'b0;
        bus_byte_enable  = 4'b0000;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus_address     = addr;
        bus_read_enable = 1'b1;
        @(negedge clock);
        bus_read_enable = 1'b0;
        data            = bus_read_data;
    endtask

    // Expected line level for frame slot 0..9 (start, 8 data bits, stop).
    function automatic logic frame_bit(input logic [7:0] data, input int slot);
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return data[slot-1];
    endfunction

    // Poll STATUS until the transmitter is drained, with a cycle bound.
    task automatic wait_drained(input string tag);
        logic [31:0] d;
        d = 32'hFFFF_FFFF;
        for (int i = 0; i < 2000; i++) begin
            bus_read(A_STATUS, d);
            if (d == 32'h0000_0004) break;
        end
        check(tag, d, 32'h0000_0004);
    endtask

    initial begin
        logic [31:0] rd;
        int          zeros;

        reset            = 1'b1;
        bus_address      = 32'd0;
        bus_write_data   = 32'd0;
        bus_byte_enable  = 4'd0;
        bus_read_enable  = 1'b0;
        bus_write_enable = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clock);
        check("reset_rdata", bus_read_data, 32'd0);
        check("reset_uart_tx", 32'(uart_tx), 32'd1);
        check("reset_irq", 32'(tx_irq), 32'd1);
        reset = 1'b0;
        @(negedge clock);

        bus_read(A_STATUS, rd);
        check("status_after_reset", rd, 32'h0000_0004);
        @(negedge clock);
        check("rdata_returns_zero", bus_read_data, 32'd0);
        bus_read(A_DIVISOR, rd);
        check("divisor_reset", rd, 32'd434);
        bus_read(A_TXDATA, rd);
        check("txdata_reads_zero", rd, 32'd0);
        bus_read(A_RESVD, rd);
        check("reserved_reads_zero", rd, 32'd0);

        // ---------------- single 0x55 frame at DIVISOR=4 ----------------
        bus_write(A_DIVISOR, 32'd4, 4'b0011);
        bus_write(A_TXDATA, 32'h55, 4'b0001);
        // Hold a STATUS read for the whole frame; the data seen at sample k
        // reflects the state during frame cycle k-1.
        bus_address     = A_STATUS;
        bus_read_enable = 1'b1;
        for (int k = 0; k < 42; k++) begin
            @(negedge clock);
            if (k < 40)
                check($sformatf("frame55_slot%0d", k), 32'(uart_tx),
                      32'(frame_bit(8'h55, k / 4)));
            if (k >= 1 && k <= 40)
                check($sformatf("frame55_busy%0d", k), 32'(bus_read_data[0]), 32'd1);
            if (k == 20)
                check("frame55_irq_low", 32'(tx_irq), 32'd0);
            if (k == 41) begin
                check("frame55_idle_busy", 32'(bus_read_data[0]), 32'd0);
                check("frame55_irq_high", 32'(tx_irq), 32'd1);
                check("frame55_line_idle", 32'(uart_tx), 32'd1);
            end
        end
        bus_read_enable = 1'b0;
        @(negedge clock);

        // ---------------- overflow at DIVISOR=1 ----------------
        bus_write(A_DIVISOR, 32'd1, 4'b0011);
        for (int i = 0; i < 10; i++)
            bus_write(A_TXDATA, 32'(8'h10 + i), 4'b0001);
        // One byte left at the first pop, eight queued, the tenth dropped.
        bus_read(A_STATUS, rd);
        check("overflow_status", rd, 32'h0000_008B);
        bus_write(A_STATUS, 32'h8, 4'b0001);
        bus_read(A_STATUS, rd);
        check("overflow_cleared", 32'(rd[3]), 32'd0);
        wait_drained("overflow_drain");

        // ---------------- DIVISOR=0 runs one cycle per bit ----------------
        bus_write(A_DIVISOR, 32'd0, 4'b0011);
        bus_read(A_DIVISOR, rd);
        check("divisor_zero_read", rd, 32'd0);
        bus_write(A_TXDATA, 32'hA5, 4'b0001);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check($sformatf("frameA5_slot%0d", k), 32'(uart_tx),
                  32'(frame_bit(8'hA5, k)));
        end
        wait_drained("div0_drain");

        // ---------------- byte-lane DIVISOR write ----------------
        bus_write(A_DIVISOR, 32'd434, 4'b0011);
        bus_write(A_DIVISOR, 32'h0000_FFFF, 4'b0001);
        bus_read(A_DIVISOR, rd);
        check("divisor_lane0", rd, 32'h0000_01FF);

        // ---------------- accesses outside the window ----------------
        bus_write(A_MISS, 32'h77, 4'b1111);
        bus_write(A_MISS | 32'h8, 32'h1234, 4'b1111);
        bus_read(A_MISS | 32'h4, rd);
        check("miss_read_zero", rd, 32'd0);
        bus_read(A_STATUS, rd);
        check("miss_status_unchanged", rd, 32'h0000_0004);
        bus_read(A_DIVISOR, rd);
        check("miss_divisor_unchanged", rd, 32'h0000_01FF);
        check("miss_no_frame", 32'(uart_tx), 32'd1);

        // ---------------- read and write in the same cycle ----------------
        bus_address      = A_DIVISOR;
        bus_write_data   = 32'd4;
        bus_byte_enable  = 4'b0011;
        bus_read_enable  = 1'b1;
        bus_write_enable = 1'b1;
        @(negedge clock);
        bus_read_enable  = 1'b0;
        bus_write_enable = 1'b0;
        bus_byte_enable  = 4'b0000;
        check("rw_same_cycle_old", bus_read_data, 32'h0000_01FF);
        bus_read(A_DIVISOR, rd);
        check("rw_same_cycle_new", rd, 32'd4);

        // ---------------- reset during DATA bit 3 ----------------
        bus_write(A_TXDATA, 32'h55, 4'b0001);
        repeat (18) @(negedge clock);  // frame cycle 17: bit 3 of 0x55
        check("pre_reset_bit3", 32'(uart_tx), 32'd0);
        reset = 1'b1;
        #1;
        check("reset_async_tx", 32'(uart_tx), 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        bus_read(A_STATUS, rd);
        check("post_reset_status", rd, 32'h0000_0004);
        zeros = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (uart_tx !== 1'b1) zeros++;
        end
        check("post_reset_no_frame", 32'(zeros), 32'd0);
        check("post_reset_irq", 32'(tx_irq), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
